sdiv_arbiter: RTL

Shares one sequential divider datapath (Load/Shift/Sub/Compare controller with Start/Ready handshake) between two requesters. Arbitrates round-robin and latches the winner's operands. Launches the divider with a one-cycle start pulse, then waits for completion and returns the quotient/remainder to the granted requester with a one-cycle done pulse. Traps divide-by-zero without touching the divider. Recovers from a hung divider through a timeout and abort.

---
 rtl/sdiv_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sdiv_arbiter.sv
// Two-requester front end for a shared sequential divider: round-robin grant,
// operand latching, start/ready handshake, divide-by-zero trap and timeout abort.
module sdiv_arbiter #(
   parameter int W       = 8,
   parameter int TIMEOUT = 64,
   parameter int CW      = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [W-1:0] dividend0,
   input  logic [W-1:0] divisor0,
   input  logic         req1,
   input  logic [W-1:0] dividend1,
   input  logic [W-1:0] divisor1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         err,
   output logic         busy,
   output logic         div_start,
   output logic [W-1:0] div_dividend,
   output logic [W-1:0] div_divisor,
   output logic         div_abort,
   input  logic         div_ready,
   input  logic [W-1:0] div_quotient,
   input  logic [W-1:0] div_remainder
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           rr;
   logic           id;
   logic [CW-1:0]  cnt;

   logic           accept;
   logic           win;
   logic [W-1:0]   win_dividend;
   logic [W-1:0]   win_divisor;
   logic           complete;
   logic           timeout_hit;
   logic [W-1:0]   quotient_next;
   logic [W-1:0]   remainder_next;
   logic           err_next;

   // Winner selection: a lone request always wins, a tie goes to the rr pointer.
   always_comb begin
      accept       = (state == IDLE) && (req0 || req1) && div_ready;
      win          = (req0 && req1) ? rr : req1;
      win_dividend = win ? dividend1 : dividend0;
      win_divisor  = win ? divisor1  : divisor0;
   end

   // Completion beats a coincident timeout, so the timeout term excludes it.
   always_comb begin
      complete    = (state == WAIT_DONE) && div_ready;
      timeout_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                    (cnt == CW'(TIMEOUT - 1)) && !complete;
   end

   // Next state and the result values loaded on entry to RESP.
   always_comb begin
      state_next     = state;
      quotient_next  = quotient;
      remainder_next = remainder;
      err_next       = err;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            // A zero divisor never reaches the divider; div_start was withheld at acceptance.
            if (div_divisor == '0) begin
               state_next     = RESP;
               quotient_next  = '1;
               remainder_next = div_dividend;
               err_next       = 1'b1;
            end else begin
               state_next = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (timeout_hit) begin
               state_next     = RESP;
               quotient_next  = '0;
               remainder_next = '0;
               err_next       = 1'b1;
            end else if (!div_ready) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (complete) begin
               state_next     = RESP;
               quotient_next  = div_quotient;
               remainder_next = div_remainder;
               err_next       = 1'b0;
            end else if (timeout_hit) begin
               state_next     = RESP;
               quotient_next  = '0;
               remainder_next = '0;
               err_next       = 1'b1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every output is a flop; the counter measures cycles since div_start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rr           <= 1'b0;
         id           <= 1'b0;
         cnt          <= '0;
         gnt0         <= 1'b0;
         gnt1         <= 1'b0;
         done0        <= 1'b0;
         done1        <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
         err          <= 1'b0;
         busy         <= 1'b0;
         div_start    <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         div_abort    <= 1'b0;
      end else begin
         state     <= state_next;
         gnt0      <= accept && !win;
         gnt1      <= accept && win;
         div_start <= accept && (win_divisor != '0);
         div_abort <= timeout_hit;
         busy      <= (state_next != IDLE);
         done0     <= (state_next == RESP) && !id;
         done1     <= (state_next == RESP) && id;
         quotient  <= quotient_next;
         remainder <= remainder_next;
         err       <= err_next;
         if (accept) begin
            id           <= win;
            div_dividend <= win_dividend;
            div_divisor  <= win_divisor;
            cnt          <= '0;
         end else if ((state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE)) begin
            cnt <= cnt + CW'(1);
         end
         if (state == RESP) begin
            rr <= ~id;
         end
      end
   end

endmodule
